// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants for the data-memory access controller:
//               FSM state encoding, funct3 size codes, legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Size legality and natural alignment folded into one check.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_SB)
              || ((f3 == F3_SH) && !lo[0])
              || ((f3 == F3_SW) && (lo == 2'b00));
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LBU)
              || (((f3 == F3_LH) || (f3 == F3_LHU)) && !lo[0])
              || ((f3 == F3_LW) && (lo == 2'b00));
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/halfword lane of a read word and
//               sign- or zero-extends it according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    import riscv_pkg::*;

    logic [31:0] w_shifted;

    assign w_shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = w_shifted;
        case (funct3_i)
            F3_LB:   data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  data_o = {24'h000000, w_shifted[7:0]};
            F3_LHU:  data_o = {16'h0000, w_shifted[15:0]};
            default: data_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store unit front end: checks size/alignment, stalls the
//               pipeline, issues one data-memory request and returns the
//               aligned load result. Optional ack watchdog: DMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  funct3_q;
    logic [31:0] load_data_q;

    logic        w_access;
    logic        w_is_store;
    logic        w_legal;
    logic        w_start;
    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;
    logic        w_timeout;

    // A simultaneous read+write request is handled as a store.
    assign w_is_store = mem_write;
    assign w_access   = (state_q == ST_IDLE) && (mem_read || mem_write);
    assign w_legal    = access_legal(w_is_store, funct3, addr[1:0]);
    assign w_start    = w_access && w_legal;
    assign w_bad      = w_access && !w_legal;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        if (w_is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << addr[1:0];
                    w_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = wdata;
                end
            endcase
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (w_start) begin
            cnt_q <= '0;
        end else if (state_q == ST_REQ) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_start) state_d = ST_REQ;
            ST_REQ: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                end else if (w_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        dmem_req   = 1'b0;
        load_valid = 1'b0;
        access_err = 1'b0;
        bus_error  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall      = w_start;
                access_err = w_bad;
            end
            ST_REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
            end
            ST_DONE: load_valid = !we_q;
`ifdef DMEM_TIMEOUT_EN
            ST_ERR:  bus_error = 1'b1;
`else
            ST_ERR:  bus_error = 1'b0;
`endif
            default: stall = 1'b0;
        endcase
    end

    // Request fields stay frozen from capture until the next accepted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            off_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
        end else if (w_start) begin
            addr_q   <= {addr[31:2], 2'b00};
            off_q    <= addr[1:0];
            we_q     <= w_is_store;
            wdata_q  <= w_wdata;
            be_q     <= w_be;
            funct3_q <= funct3;
        end
    end

    load_extend u_load_extend (
        .rdata_i  (dmem_rdata),
        .offset_i (off_q),
        .funct3_i (funct3_q),
        .data_o   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            load_data_q <= '0;
        end else if ((state_q == ST_REQ) && dmem_ack && !we_q) begin
            load_data_q <= w_ext;
        end
    end

    assign load_data  = load_data_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_err;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .access_err (access_err),
        .bus_error  (bus_error),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] eaddr;
        logic        we;
        logic [31:0] ewdata;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs [16];
    vec_t v;
    logic [31:0] last_ld;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 1'b0, 4'b1111, 32'h100, 1'b0, 32'h0, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 1'b0, 4'b1111, 32'h100, 1'b0, 32'h0, 32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234, 32'h0, 1'b0, 4'b1100, 32'h200, 1'b1, 32'h12341234, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'hFFFF12AB, 32'h0, 1'b0, 4'b0010, 32'h300, 1'b1, 32'hABABABAB, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0, 1'b0, 4'b1111, 32'h404, 1'b1, 32'hCAFEF00D, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h52, 32'h0, 32'h80017FFF, 1'b0, 4'b1111, 32'h50, 1'b0, 32'h0, 32'hFFFF8001};
        vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h50, 32'h0, 32'h8001F00F, 1'b0, 4'b1111, 32'h50, 1'b0, 32'h0, 32'h0000F00F};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h60, 32'h0, 32'h12345678, 1'b0, 4'b1111, 32'h60, 1'b0, 32'h0, 32'h00005678};
        vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h71, 32'h0, 32'h00007F00, 1'b0, 4'b1111, 32'h70, 1'b0, 32'h0, 32'h0000007F};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b1, 1'b1, 3'b010, 32'h10, 32'h11223344, 32'hFFFFFFFF, 1'b0, 4'b1111, 32'h10, 1'b1, 32'h11223344, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b101, 32'h21, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0};

        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        wdata      = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        last_ld    = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_access_err", access_err, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_dmem_be", dmem_be, 0);
        chk("rst_load_data", load_data, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            v         = vecs[i];
            mem_read  = v.mr;
            mem_write = v.mw;
            funct3    = v.f3;
            addr      = v.addr;
            wdata     = v.wdata;
            dmem_ack  = 1'b0;
            #1;
            chk($sformatf("v%0d_idle_stall", i), stall, !v.err);
            chk($sformatf("v%0d_access_err", i), access_err, v.err);
            chk($sformatf("v%0d_idle_req", i), dmem_req, 0);
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            if (v.err) begin
                #1;
                chk($sformatf("v%0d_err_no_req", i), dmem_req, 0);
                chk($sformatf("v%0d_err_no_stall", i), stall, 0);
                chk($sformatf("v%0d_err_one_cycle", i), access_err, 0);
                chk($sformatf("v%0d_err_ld_hold", i), load_data, last_ld);
                @(negedge clk);
            end else begin
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdata;
                #1;
                chk($sformatf("v%0d_req", i), dmem_req, 1);
                chk($sformatf("v%0d_req_stall", i), stall, 1);
                chk($sformatf("v%0d_be", i), dmem_be, v.be);
                chk($sformatf("v%0d_addr", i), dmem_addr, v.eaddr);
                chk($sformatf("v%0d_we", i), dmem_we, v.we);
                if (v.we) chk($sformatf("v%0d_wdata", i), dmem_wdata, v.ewdata);
                @(negedge clk);
                dmem_ack = 1'b0;
                #1;
                chk($sformatf("v%0d_done_stall", i), stall, 0);
                chk($sformatf("v%0d_done_req", i), dmem_req, 0);
                chk($sformatf("v%0d_load_valid", i), load_valid, !v.we);
                if (!v.we) last_ld = v.ld;
                chk($sformatf("v%0d_load_data", i), load_data, last_ld);
                @(negedge clk);
            end
        end

        // Reset in the third REQ cycle, then a late ack that must be ignored.
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h100;
        #1;
        @(negedge clk);
        mem_read = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) rst = 1'b1;
            #1;
            chk($sformatf("rstreq_c%0d_req", c), dmem_req, 1);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("rstreq_req_dropped", dmem_req, 0);
        chk("rstreq_stall_dropped", stall, 0);
        chk("rstreq_addr_cleared", dmem_addr, 0);
        chk("rstreq_load_data_cleared", load_data, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55555555;
        @(negedge clk);
        #1;
        chk("late_ack_req", dmem_req, 0);
        chk("late_ack_valid", load_valid, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("late_ack_valid2", load_valid, 0);
        chk("late_ack_load_data", load_data, 0);
        @(negedge clk);

        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0;
        #1;
        chk("wd_start_stall", stall, 1);
        @(negedge clk);
        mem_read = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("wd_c%0d_req", c), dmem_req, 1);
            chk($sformatf("wd_c%0d_stall", c), stall, 1);
            chk($sformatf("wd_c%0d_bus_error", c), bus_error, 0);
            @(negedge clk);
        end
        #1;
        chk("wd_bus_error", bus_error, 1);
        chk("wd_err_stall", stall, 0);
        chk("wd_err_req", dmem_req, 0);
        @(negedge clk);
        #1;
        chk("wd_bus_error_pulse", bus_error, 0);
        chk("wd_idle_req", dmem_req, 0);
`else
        for (int c = 0; c < 100; c++) begin
            #1;
            chk($sformatf("hold_c%0d_stall", c), stall, 1);
            chk($sformatf("hold_c%0d_bus_error", c), bus_error, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("hold_rst_stall", stall, 0);
`endif
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
